game_ctrl_fsm: RTL and testbench

- Parametrised top-level game controller for Donkey vs Kong.
- Gates the game on two-player readiness, tracks Donkey's health as a thermometer mask, applies post-hit invulnerability, and declares the winner.
- Returns to the lobby on `restart`, so multiple rounds can be played without a reset.
- Sits between the player/UART start logic, the barrel/collision units and the HUD/sprite renderers.

---
 rtl/game_ctrl_fsm_if.sv | 41 ++++
 rtl/game_ctrl_fsm.sv | 160 ++++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_fsm_if.sv
// Bus between the Donkey vs Kong game controller and its neighbours (start logic, hazards, HUD).
// Carries the optional extra_life pulse when GAME_EXTRA_LIFE_EN is defined.
interface game_ctrl_fsm_if #(
  parameter int MAX_HEALTH = 3,
  parameter int N_HAZARDS  = 10
);
  logic                  start_game;
  logic                  start_game_uart;
  logic                  animation;
  logic                  touch_lady;
  logic                  is_shielded;
  logic [N_HAZARDS-1:0]  barrel_hit;
  logic                  restart;
`ifdef GAME_EXTRA_LIFE_EN
  logic                  extra_life;
`endif
  logic                  game_en;
  logic                  donkey_hit;
  logic                  donkey_win;
  logic                  kong_win;
  logic [MAX_HEALTH-1:0] health_en;
  logic                  invuln;

  modport slave (
    input  start_game, start_game_uart, animation, touch_lady, is_shielded,
           barrel_hit, restart,
`ifdef GAME_EXTRA_LIFE_EN
    input  extra_life,
`endif
    output game_en, donkey_hit, donkey_win, kong_win, health_en, invuln
  );

  modport master (
    output start_game, start_game_uart, animation, touch_lady, is_shielded,
           barrel_hit, restart,
`ifdef GAME_EXTRA_LIFE_EN
    output extra_life,
`endif
    input  game_en, donkey_hit, donkey_win, kong_win, health_en, invuln
  );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Donkey vs Kong game controller: lobby gating, thermometer health, post-hit immunity, winner.
// Optional health restore via extra_life when GAME_EXTRA_LIFE_EN is defined.
module game_ctrl_fsm #(
  parameter int MAX_HEALTH    = 3,
  parameter int N_HAZARDS     = 10,
  parameter int INVULN_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  game_ctrl_fsm_if.slave   bus
);

  localparam int CNT_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LOAD    = CNT_W'(INVULN_CYCLES);
  localparam logic [MAX_HEALTH-1:0] HEALTH_FULL = {MAX_HEALTH{1'b1}};
  localparam logic [MAX_HEALTH-1:0] HEALTH_NONE = {MAX_HEALTH{1'b0}};
  localparam logic [MAX_HEALTH-1:0] HEALTH_ONE  = MAX_HEALTH'(1);

  typedef enum logic [1:0] {
    ST_WAIT_FOR_PLAYERS = 2'd0,
    ST_GAME             = 2'd1,
    ST_DONKEY_WIN       = 2'd2,
    ST_KONG_WIN         = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  game_en_q, game_en_d;
  logic                  donkey_hit_q, donkey_hit_d;
  logic                  donkey_win_q, donkey_win_d;
  logic                  kong_win_q, kong_win_d;
  logic                  invuln_q, invuln_d;
  logic [MAX_HEALTH-1:0] health_q, health_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_s;
  logic                  dmg_s;
  logic                  extra_s;

  assign ready_s = bus.start_game && bus.start_game_uart && !bus.animation;
  assign dmg_s   = (|bus.barrel_hit) && !bus.is_shielded && (cnt_q == CNT_ZERO)
                   && (state_q == ST_GAME);
`ifdef GAME_EXTRA_LIFE_EN
  assign extra_s = bus.extra_life;
`else
  assign extra_s = 1'b0;
`endif

  // Next-state and next-output decision for every registered output.
  always_comb begin
    state_d      = state_q;
    game_en_d    = game_en_q;
    donkey_hit_d = 1'b0;
    donkey_win_d = donkey_win_q;
    kong_win_d   = kong_win_q;
    health_d     = health_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_WAIT_FOR_PLAYERS: begin
        health_d     = bus.animation ? HEALTH_NONE : HEALTH_FULL;
        donkey_win_d = 1'b0;
        kong_win_d   = 1'b0;
        cnt_d        = CNT_ZERO;
        if (ready_s) begin
          state_d   = ST_GAME;
          game_en_d = 1'b1;
        end else begin
          game_en_d = 1'b0;
        end
      end
      ST_GAME: begin
        donkey_win_d = 1'b0;
        kong_win_d   = 1'b0;
        if (bus.restart) begin
          state_d   = ST_WAIT_FOR_PLAYERS;
          game_en_d = 1'b0;
          cnt_d     = CNT_ZERO;
          health_d  = HEALTH_NONE;
        end else if (bus.touch_lady) begin
          // A hit landing together with the lady touch is discarded.
          state_d      = ST_DONKEY_WIN;
          game_en_d    = 1'b0;
          donkey_win_d = 1'b1;
          cnt_d        = CNT_ZERO;
        end else if (health_q == HEALTH_NONE) begin
          state_d    = ST_KONG_WIN;
          game_en_d  = 1'b0;
          kong_win_d = 1'b1;
          cnt_d      = CNT_ZERO;
        end else begin
          game_en_d = 1'b1;
          if (dmg_s) begin
            donkey_hit_d = 1'b1;
            cnt_d        = CNT_LOAD;
            health_d     = extra_s ? health_q : (health_q >> 1);
          end else begin
            cnt_d = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : CNT_ZERO;
            if (extra_s && (health_q != HEALTH_FULL)) begin
              health_d = (health_q << 1) | HEALTH_ONE;
            end else begin
              health_d = health_q;
            end
          end
        end
      end
      ST_DONKEY_WIN, ST_KONG_WIN: begin
        game_en_d = 1'b0;
        cnt_d     = CNT_ZERO;
        if (bus.restart) begin
          state_d      = ST_WAIT_FOR_PLAYERS;
          donkey_win_d = 1'b0;
          kong_win_d   = 1'b0;
        end else begin
          donkey_win_d = (state_q == ST_DONKEY_WIN);
          kong_win_d   = (state_q == ST_KONG_WIN);
        end
      end
      default: begin
        state_d      = ST_WAIT_FOR_PLAYERS;
        game_en_d    = 1'b0;
        donkey_win_d = 1'b0;
        kong_win_d   = 1'b0;
        health_d     = HEALTH_NONE;
        cnt_d        = CNT_ZERO;
      end
    endcase
    invuln_d = (cnt_d != CNT_ZERO);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_FOR_PLAYERS;
      game_en_q    <= 1'b0;
      donkey_hit_q <= 1'b0;
      donkey_win_q <= 1'b0;
      kong_win_q   <= 1'b0;
      invuln_q     <= 1'b0;
      health_q     <= HEALTH_NONE;
      cnt_q        <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      game_en_q    <= game_en_d;
      donkey_hit_q <= donkey_hit_d;
      donkey_win_q <= donkey_win_d;
      kong_win_q   <= kong_win_d;
      invuln_q     <= invuln_d;
      health_q     <= health_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.game_en    = game_en_q;
  assign bus.donkey_hit = donkey_hit_q;
  assign bus.donkey_win = donkey_win_q;
  assign bus.kong_win   = kong_win_q;
  assign bus.health_en  = health_q;
  assign bus.invuln     = invuln_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: heart-count model checked every cycle plus literal spot checks.
module tb_game_ctrl_fsm;
  localparam int MH  = 3;
  localparam int NH  = 10;
  localparam int INV = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   run_cmp;

  game_ctrl_fsm_if #(.MAX_HEALTH(MH), .N_HAZARDS(NH)) bus ();

  game_ctrl_fsm #(.MAX_HEALTH(MH), .N_HAZARDS(NH), .INVULN_CYCLES(INV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 lobby, 1 playing, 2 Donkey won, 3 Kong won; health kept as a heart count.
  int phase, hearts, imm;
  bit e_ge, e_hit, e_dw, e_kw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; hearts = 0; imm = 0;
      e_ge = 0; e_hit = 0; e_dw = 0; e_kw = 0;
    end else begin
      bit dmg;
      bit el;
      dmg = (bus.barrel_hit != 0) && !bus.is_shielded && (imm == 0) && (phase == 1);
      el = 0;
`ifdef GAME_EXTRA_LIFE_EN
      el = bus.extra_life;
`endif
      e_hit = 0;
      case (phase)
        0: begin
          hearts = bus.animation ? 0 : MH;
          imm = 0; e_dw = 0; e_kw = 0;
          e_ge = bus.start_game && bus.start_game_uart && !bus.animation;
          if (e_ge) phase = 1;
        end
        1: begin
          if (bus.restart) begin
            phase = 0; e_ge = 0; imm = 0; hearts = 0;
          end else if (bus.touch_lady) begin
            phase = 2; e_ge = 0; e_dw = 1; imm = 0;
          end else if (hearts == 0) begin
            phase = 3; e_ge = 0; e_kw = 1; imm = 0;
          end else begin
            e_hit = dmg;
            if (dmg) begin
              imm = INV;
              if (!el) hearts = hearts - 1;
            end else begin
              if (imm > 0) imm = imm - 1;
              if (el && hearts < MH) hearts = hearts + 1;
            end
          end
        end
        default: begin
          e_ge = 0; imm = 0;
          if (bus.restart) begin
            phase = 0; e_dw = 0; e_kw = 0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      logic [MH-1:0] e_h;
      e_h = MH'((1 << hearts) - 1);
      chk("m_game_en",    32'(bus.game_en),    32'(e_ge));
      chk("m_donkey_hit", 32'(bus.donkey_hit), 32'(e_hit));
      chk("m_donkey_win", 32'(bus.donkey_win), 32'(e_dw));
      chk("m_kong_win",   32'(bus.kong_win),   32'(e_kw));
      chk("m_health_en",  32'(bus.health_en),  32'(e_h));
      chk("m_invuln",     32'(bus.invuln),     32'(imm != 0));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic all_zero(input string name);
    chk({name, "_ge"},  32'(bus.game_en),    32'd0);
    chk({name, "_hit"}, 32'(bus.donkey_hit), 32'd0);
    chk({name, "_dw"},  32'(bus.donkey_win), 32'd0);
    chk({name, "_kw"},  32'(bus.kong_win),   32'd0);
    chk({name, "_h"},   32'(bus.health_en),  32'd0);
    chk({name, "_inv"}, 32'(bus.invuln),     32'd0);
  endtask

  task automatic hit_once(input logic [NH-1:0] pattern);
    bus.barrel_hit = pattern;
    step(1);
    bus.barrel_hit = 10'h000;
  endtask

  initial begin
    checks = 0; errors = 0; run_cmp = 0;
    rst_n = 1'b0;
    bus.start_game = 1'b0; bus.start_game_uart = 1'b0; bus.animation = 1'b0;
    bus.touch_lady = 1'b0; bus.is_shielded = 1'b0; bus.barrel_hit = 10'h000;
    bus.restart = 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
    bus.extra_life = 1'b0;
`endif
    #12;
    all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp = 1;

    // Readiness blocked by the intro animation.
    bus.start_game = 1'b1; bus.start_game_uart = 1'b1; bus.animation = 1'b1;
    step(2);
    chk("anim_h",  32'(bus.health_en), 32'h0);
    chk("anim_ge", 32'(bus.game_en),   32'h0);
    bus.animation = 1'b0;
    step(1);
    chk("ready_h",  32'(bus.health_en), 32'h7);
    chk("ready_ge", 32'(bus.game_en),   32'h1);
    bus.start_game = 1'b0; bus.start_game_uart = 1'b0;

    // Two barrels at once count as one hit, then immunity.
    bus.barrel_hit = 10'h003;
    step(1);
    chk("hit1_pulse", 32'(bus.donkey_hit), 32'h1);
    chk("hit1_h",     32'(bus.health_en),  32'h3);
    chk("hit1_inv",   32'(bus.invuln),     32'h1);
    step(3);
    chk("imm_h",   32'(bus.health_en),  32'h3);
    chk("imm_inv", 32'(bus.invuln),     32'h1);
    chk("imm_hit", 32'(bus.donkey_hit), 32'h0);
    step(1);
    chk("imm_end_inv", 32'(bus.invuln),    32'h0);
    chk("imm_end_h",   32'(bus.health_en), 32'h3);

    // Shield blocks hits.
    bus.barrel_hit = 10'h200; bus.is_shielded = 1'b1;
    step(2);
    chk("shield_hit", 32'(bus.donkey_hit), 32'h0);
    chk("shield_h",   32'(bus.health_en),  32'h3);
    chk("shield_inv", 32'(bus.invuln),     32'h0);
    bus.is_shielded = 1'b0;
    step(1);
    chk("hit2_h", 32'(bus.health_en), 32'h1);
    bus.barrel_hit = 10'h000;

    // Fatal hit together with the lady touch: Donkey wins.
    step(5);
    bus.barrel_hit = 10'h001; bus.touch_lady = 1'b1;
    step(1);
    bus.barrel_hit = 10'h000; bus.touch_lady = 1'b0;
    chk("lady_dw", 32'(bus.donkey_win), 32'h1);
    chk("lady_kw", 32'(bus.kong_win),   32'h0);
    chk("lady_h",  32'(bus.health_en),  32'h1);
    step(2);
    chk("lady_hold", 32'(bus.donkey_win), 32'h1);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("dw_restart", 32'(bus.donkey_win), 32'h0);

    // Kong win after three spaced hits.
    bus.start_game = 1'b1; bus.start_game_uart = 1'b1;
    step(2);
    bus.start_game = 1'b0; bus.start_game_uart = 1'b0;
    chk("round2_ge", 32'(bus.game_en), 32'h1);
    hit_once(10'h010); step(5);
    hit_once(10'h010); step(5);
    hit_once(10'h010);
    chk("fatal_h",  32'(bus.health_en), 32'h0);
    chk("fatal_kw", 32'(bus.kong_win),  32'h0);
    step(1);
    chk("kong_kw", 32'(bus.kong_win), 32'h1);
    chk("kong_ge", 32'(bus.game_en),  32'h0);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("kw_restart", 32'(bus.kong_win), 32'h0);
    step(1);
    chk("lobby_h", 32'(bus.health_en), 32'h7);

    // Restart in the lobby does nothing; restart mid-game aborts.
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("lobby_restart_ge", 32'(bus.game_en), 32'h0);
    bus.start_game = 1'b1; bus.start_game_uart = 1'b1;
    step(1);
    bus.start_game = 1'b0; bus.start_game_uart = 1'b0;
    step(1);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("abort_ge", 32'(bus.game_en),   32'h0);
    chk("abort_h",  32'(bus.health_en), 32'h0);
    step(1);

    // Asynchronous reset in the middle of a round.
    bus.start_game = 1'b1; bus.start_game_uart = 1'b1;
    step(1);
    bus.start_game = 1'b0; bus.start_game_uart = 1'b0;
    hit_once(10'h100);
    chk("pre_rst_inv", 32'(bus.invuln), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_h",  32'(bus.health_en), 32'h7);
    chk("post_rst_ge", 32'(bus.game_en),   32'h0);
    bus.start_game = 1'b1; bus.start_game_uart = 1'b1;
    step(1);
    chk("post_rst_start", 32'(bus.game_en), 32'h1);
    step(2);

    run_cmp = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
